// File: rtl/llr_lrb_finder_seq.sv
// llr_lrb_finder_seq
// Scans one codeword of LLR magnitudes, one symbol per enabled cycle, and keeps
// the NUM_LRB smallest magnitudes together with their symbol indices. The
// result feeds Chase test-pattern generation in the soft BCH decoder.
//
// Ports:
//   clk            rising-edge clock
//   in_ctr_Arst_n  asynchronous active-low reset
//   in_ctr_start   one-cycle pulse, clears the slots and begins a scan
//   in_ctr_en      in_llr_mag is valid this cycle
//   in_llr_mag     magnitude of the current symbol
//   out_busy       scan in progress (COLLECT)
//   out_done       one-cycle pulse after the CW_LEN-th accepted symbol
//   out_lrb_mag    sorted magnitudes, slot 0 (LSB field) is the smallest
//   out_lrb_idx    symbol index of each slot; all-ones means "no entry"
module llr_lrb_finder_seq #(
    parameter int MAG_LEN = 3,
    parameter int CW_LEN  = 15,
    parameter int IDX_LEN = 4,
    parameter int NUM_LRB = 2
) (
    input  logic                       clk,
    input  logic                       in_ctr_Arst_n,
    input  logic                       in_ctr_start,
    input  logic                       in_ctr_en,
    input  logic [MAG_LEN-1:0]         in_llr_mag,
    output logic                       out_busy,
    output logic                       out_done,
    output logic [NUM_LRB*MAG_LEN-1:0] out_lrb_mag,
    output logic [NUM_LRB*IDX_LEN-1:0] out_lrb_idx
);

    localparam logic [IDX_LEN-1:0] LAST = IDX_LEN'(CW_LEN - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, HOLD} state_t;

    state_t                             state, state_nxt;
    logic [IDX_LEN-1:0]                 cnt, cnt_nxt, cnt_base;
    logic [NUM_LRB-1:0][MAG_LEN-1:0]    mag_q, mag_nxt, mag_base;
    logic [NUM_LRB-1:0][IDX_LEN-1:0]    idx_q, idx_nxt, idx_base;
    logic [NUM_LRB-1:0]                 lt;
    logic                               accept;

    // Next-state, counter and insertion sort. A start pulse first reduces the
    // slots/counter to their cleared values ("base"), so a symbol arriving with
    // start is sorted into an empty table as index 0.
    always_comb begin
        state_nxt = state;
        mag_base  = mag_q;
        idx_base  = idx_q;
        cnt_base  = cnt;
        accept    = 1'b0;
        lt        = '0;

        if (in_ctr_start) begin
            state_nxt = COLLECT;
            mag_base  = '1;
            idx_base  = '1;
            cnt_base  = '0;
        end else if (state == DONE) begin
            state_nxt = HOLD;
        end

        accept  = in_ctr_en && (in_ctr_start || state == COLLECT);
        cnt_nxt = cnt_base;
        if (accept) begin
            cnt_nxt = cnt_base + 1'b1;
            if (cnt_base == LAST)
                state_nxt = DONE;
        end

        // Slots are sorted ascending, so lt is a thermometer code: the first
        // set bit is the insertion slot, later set bits take their lower
        // neighbour. Strict compare keeps the earlier index on ties.
        for (int i = 0; i < NUM_LRB; i++)
            lt[i] = in_llr_mag < mag_base[i];

        mag_nxt = mag_base;
        idx_nxt = idx_base;
        if (accept) begin
            if (lt[0]) begin
                mag_nxt[0] = in_llr_mag;
                idx_nxt[0] = cnt_base;
            end
            for (int i = 1; i < NUM_LRB; i++) begin
                if (lt[i]) begin
                    mag_nxt[i] = lt[i-1] ? mag_base[i-1] : in_llr_mag;
                    idx_nxt[i] = lt[i-1] ? idx_base[i-1] : cnt_base;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mag_q <= '1;
            idx_q <= '1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mag_q <= mag_nxt;
            idx_q <= idx_nxt;
        end
    end

    // All outputs are decodes of flops; no input-to-output path.
    assign out_busy    = (state == COLLECT);
    assign out_done    = (state == DONE);
    assign out_lrb_mag = mag_q;
    assign out_lrb_idx = idx_q;

endmodule

// File: tb/tb_llr_lrb_finder_seq.sv
module tb_llr_lrb_finder_seq;
    localparam int MAG_LEN = 3;
    localparam int CW_LEN  = 15;
    localparam int IDX_LEN = 4;
    localparam int NUM_LRB = 2;
    localparam int MAXM    = (1 << MAG_LEN) - 1;
    localparam int MAXI    = (1 << IDX_LEN) - 1;

    typedef logic [MAG_LEN-1:0] mag_arr_t [CW_LEN];

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic                       en = 1'b0;
    logic [MAG_LEN-1:0]         mag = '0;
    logic                       busy, done;
    logic [NUM_LRB*MAG_LEN-1:0] lrb_mag;
    logic [NUM_LRB*IDX_LEN-1:0] lrb_idx;

    int checks = 0;
    int failures = 0;

    // reference model: scan mode plus the list of accepted magnitudes
    int m_mode;                 // 0 idle, 1 collecting, 2 done pulse, 3 holding
    int m_cnt;
    int m_mags [CW_LEN];

    llr_lrb_finder_seq #(.MAG_LEN(MAG_LEN), .CW_LEN(CW_LEN), .IDX_LEN(IDX_LEN), .NUM_LRB(NUM_LRB)) dut (
        .clk(clk), .in_ctr_Arst_n(rst_n), .in_ctr_start(start), .in_ctr_en(en),
        .in_llr_mag(mag), .out_busy(busy), .out_done(done),
        .out_lrb_mag(lrb_mag), .out_lrb_idx(lrb_idx));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected slots: the NUM_LRB smallest accepted magnitudes below max,
    // ordered by (magnitude, index); unused slots are all-ones.
    task automatic expected(output logic [NUM_LRB*MAG_LEN-1:0] em, output logic [NUM_LRB*IDX_LEN-1:0] ei);
        bit used [CW_LEN];
        for (int j = 0; j < CW_LEN; j++) used[j] = 1'b0;
        em = '1;
        ei = '1;
        for (int s = 0; s < NUM_LRB; s++) begin
            int best = -1;
            for (int j = 0; j < m_cnt; j++)
                if (!used[j] && m_mags[j] < MAXM && (best < 0 || m_mags[j] < m_mags[best]))
                    best = j;
            if (best >= 0) begin
                used[best] = 1'b1;
                em[s*MAG_LEN +: MAG_LEN] = MAG_LEN'(m_mags[best]);
                ei[s*IDX_LEN +: IDX_LEN] = IDX_LEN'(best);
            end
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic s, input logic e, input int v);
        if (s) begin
            m_cnt  = 0;
            m_mode = 1;
            if (e) begin m_mags[0] = v; m_cnt = 1; end
        end else if (m_mode == 1) begin
            if (e) begin m_mags[m_cnt] = v; m_cnt++; end
        end else if (m_mode == 2) begin
            m_mode = 3;
        end
        if (m_mode == 1 && m_cnt == CW_LEN) m_mode = 2;
    endtask

    task automatic compare_all(input string tag);
        logic [NUM_LRB*MAG_LEN-1:0] em;
        logic [NUM_LRB*IDX_LEN-1:0] ei;
        expected(em, ei);
        chk({tag, "_busy"}, 32'(busy), 32'(m_mode == 1));
        chk({tag, "_done"}, 32'(done), 32'(m_mode == 2));
        chk({tag, "_mag"},  32'(lrb_mag), 32'(em));
        chk({tag, "_idx"},  32'(lrb_idx), 32'(ei));
    endtask

    // One clock: compare outputs on the falling edge, then drive the next inputs.
    task automatic cycle(input logic s, input logic e, input logic [MAG_LEN-1:0] v);
        @(negedge clk);
        compare_all("cyc");
        start = s; en = e; mag = v;
        model_step(s, e, int'(v));
    endtask

    task automatic scan(input mag_arr_t d, input int stall_at, input int stall_len);
        for (int i = 0; i < CW_LEN; i++) begin
            if (i == stall_at)
                for (int k = 0; k < stall_len; k++) cycle(1'b0, 1'b0, MAG_LEN'($urandom));
            cycle(i == 0, 1'b1, d[i]);
        end
        cycle(1'b0, 1'b0, '0);      // outputs now show the done cycle
    endtask

    task automatic lit(input string name, input logic d, input logic [NUM_LRB*MAG_LEN-1:0] em,
                       input logic [NUM_LRB*IDX_LEN-1:0] ei);
        chk({name, "_done"}, 32'(done), 32'(d));
        chk({name, "_mag"}, 32'(lrb_mag), 32'(em));
        chk({name, "_idx"}, 32'(lrb_idx), 32'(ei));
    endtask

    mag_arr_t d1, dt, d7, dr;

    initial begin
        d1 = '{3'd7,3'd7,3'd3,3'd7,3'd1,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd7,3'd2,3'd7};
        for (int i = 0; i < CW_LEN; i++) begin dt[i] = 3'd5; d7[i] = 3'd7; dr[i] = MAG_LEN'($urandom); end
        dt[9] = 3'd0;
        model_reset();

        // reset state
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mag", 32'(lrb_mag), 32'(MAXM * 9));
        chk("reset_idx", 32'(lrb_idx), 32'(MAXI * 17));
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 3'd0);    // en without start is ignored in IDLE
        cycle(1'b0, 1'b0, 3'd0);

        scan(d1, -1, 0);
        lit("plan1", 1'b1, {3'd2, 3'd1}, {4'd13, 4'd4});
        cycle(1'b0, 1'b1, 3'd0);    // HOLD ignores en
        cycle(1'b0, 1'b0, 3'd0);
        lit("hold", 1'b0, {3'd2, 3'd1}, {4'd13, 4'd4});

        scan(dt, -1, 0);
        lit("ties", 1'b1, {3'd5, 3'd0}, {4'd0, 4'd9});

        scan(d7, -1, 0);
        lit("all7", 1'b1, 6'h3f, 8'hff);

        scan(d1, 6, 3);
        lit("stall", 1'b1, {3'd2, 3'd1}, {4'd13, 4'd4});

        // restart: abort a scan at symbol 8 with start+en
        for (int i = 0; i < 8; i++) cycle(i == 0, 1'b1, dr[i]);
        scan(d1, -1, 0);
        lit("restart", 1'b1, {3'd2, 3'd1}, {4'd13, 4'd4});

        // start while the done pulse is showing
        for (int i = 0; i < CW_LEN; i++) cycle(i == 0, 1'b1, dr[i]);
        cycle(1'b1, 1'b1, 3'd6);
        for (int i = 1; i < CW_LEN; i++) cycle(1'b0, 1'b1, dt[i]);
        cycle(1'b0, 1'b0, 3'd0);
        cycle(1'b0, 1'b0, 3'd0);

        // async reset between edges mid-scan
        for (int i = 0; i < 6; i++) cycle(i == 0, 1'b1, MAG_LEN'($urandom));
        #2 start = 1'b0; en = 1'b0; rst_n = 1'b0;
        #1;
        lit("arst", 1'b0, 6'h3f, 8'hff);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        cycle(1'b0, 1'b0, 3'd0);

        // random traffic
        for (int n = 0; n < 1500; n++)
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 3'd7 : MAG_LEN'($urandom));
        cycle(1'b0, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/llr_lrb_finder_seq.md
Name: llr_lrb_finder_seq

Overview:
- Downstream consumer of the sequential LLR magnitude stage.
- Scans one codeword of LLR magnitudes, one symbol per enabled cycle.
- Tracks the NUM_LRB least reliable bits (smallest magnitudes) and their symbol indices.
- Results feed Chase test-pattern generation in the soft BCH decoder.

Parameters:
- MAG_LEN, 3, magnitude width (upstream LLR_LEN - 1).
- CW_LEN, 15, symbols per codeword.
- IDX_LEN, 4, index width; must satisfy 2^IDX_LEN >= CW_LEN.
- NUM_LRB, 2, number of least-reliable positions tracked (1..4).

Ports:
- clk  input  1  rising-edge clock.
- in_ctr_Arst_n  input  1  asynchronous, active-low reset.
- in_ctr_start  input  1  single-cycle pulse that begins a new codeword scan.
- in_ctr_en  input  1  in_llr_mag valid this cycle.
- in_llr_mag  input  MAG_LEN  magnitude of the current symbol.
- out_busy  output  1  scan in progress.
- out_done  output  1  one-cycle pulse when the scan completes.
- out_lrb_mag  output  NUM_LRB*MAG_LEN  sorted magnitudes; slot 0 (LSB field) is the smallest.
- out_lrb_idx  output  NUM_LRB*IDX_LEN  symbol indices matching each out_lrb_mag slot.

Behaviour:
- Reset (async assert, sync-safe release) sets:
  - state to IDLE; counter to 0.
  - all mag slots to all-ones (2^MAG_LEN - 1); all idx slots to all-ones.
  - out_busy = 0, out_done = 0.
- FSM states:
  - IDLE: in_ctr_start -> COLLECT.
  - COLLECT: after the CW_LEN-th accepted symbol -> DONE; in_ctr_start -> restart in COLLECT.
  - DONE: out_done = 1 for exactly this cycle, then -> HOLD.
  - HOLD: results stay stable; in_ctr_start -> COLLECT.
- Start handling:
  - Start clears all slots to reset values and the counter to 0.
  - Start with en in the same cycle: the clear is applied and that symbol is accepted as index 0.
- Accept rule: in COLLECT with in_ctr_en = 1, the symbol gets index = counter, then the counter increments.
- en = 0 in COLLECT holds all state (stall); no timeout.
- en in IDLE, DONE or HOLD without start is ignored.
- Insertion sort, applied within the accepting cycle:
  - Find the lowest slot k where in_llr_mag < mag[k] (strict compare).
  - Slots k..NUM_LRB-2 shift up one position; the new entry goes into slot k.
  - No such slot: the symbol is discarded.
- Ties: the earlier index keeps the lower slot; a later equal magnitude lands after it or is dropped.
- An all-ones magnitude never displaces an all-ones slot, so an all-max codeword leaves idx at all-ones. Downstream treats idx all-ones as "no entry".
- Latency: slot registers update on the clock edge that accepts the symbol. out_done asserts the cycle after the last accepted symbol.
- out_busy = 1 in COLLECT only; it drops in the same cycle out_done rises.
- Counter wrap: the counter only reaches CW_LEN - 1 before the transition, so no wrap. CW_LEN = 2^IDX_LEN is legal.
- Outputs are registered (no combinational path from inputs to outputs).
- Reset asserted mid-scan aborts immediately to reset values; no done pulse.
- in_ctr_start during DONE: the done pulse still occurs this cycle, slots clear on the same edge, next state is COLLECT.

Test Plan:
- Reset then start; stream 15 mags 7,7,3,7,1,7,7,7,7,7,7,7,7,2,7 -> out_done 1 cycle after the 15th symbol; slot0 = (1, idx 4), slot1 = (2, idx 13).
- Ties: mags all 5 except idx 6 = 5 and idx 9 = 0 -> slot0 = (0, 9), slot1 = (5, 0); earlier index wins.
- All-7 codeword -> mags 7,7 and idx 15,15; done still pulses after 15 accepted symbols.
- Stall: en deasserted for 3 cycles between symbols 5 and 6 -> identical result to the unstalled run; done delayed by 3 cycles.
- Restart: start asserted with en at symbol 8 of a scan -> counter restarts at 0 with that symbol as idx 0; only the new 15 symbols count; no done for the aborted scan.
- Async reset pulsed mid-scan (between edges) -> outputs return to reset values immediately; busy = 0; no done.
